// File: rtl/fifo_pkg.sv
// Shared constants and types for the watermark FIFO (fifo_umbral) and its storage.
package fifo_pkg;

  localparam int FIFO_DATA_W = 6;
  localparam int FIFO_DEPTH  = 8;
  // Threshold width is shared with the control FSM's latched threshold buses.
  localparam int UMBRAL_W    = 5;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } flags_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write port, registered read port.
// The array itself is never reset; only the read register is.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address read/write returns the old word, which is what a full
  // FIFO doing push+pop needs.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-empty/almost-full watermarks and a
// sticky overflow/underflow error. Define FIFO_UMBRAL_ERR_CLR_EN to add err_clr.
module fifo_umbral
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
`ifdef FIFO_UMBRAL_ERR_CLR_EN
  input  logic                err_clr,
`endif
  input  logic                push,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                pop,
  output logic [DATA_W-1:0]   data_out,
  output logic                valid_out,
  input  logic [UMBRAL_W-1:0] umbral_low,
  input  logic [UMBRAL_W-1:0] umbral_high,
  output logic                empty,
  output logic                full,
  output logic                almost_empty,
  output logic                almost_full,
  output logic                error,
  output logic [PTR_W:0]      count
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic                wr_ok, rd_ok, ovf, udf, err_nxt;
  logic [UMBRAL_W-1:0] cnt_ext;
  flags_t              flg;

  // Flags are combinational on the registered count and live thresholds.
  assign cnt_ext          = UMBRAL_W'(count);
  assign flg.empty        = (count == '0);
  assign flg.full         = (count == CNT_W'(DEPTH));
  assign flg.almost_empty = (cnt_ext <= umbral_low);
  assign flg.almost_full  = (cnt_ext >= umbral_high);

  assign empty        = flg.empty;
  assign full         = flg.full;
  assign almost_empty = flg.almost_empty;
  assign almost_full  = flg.almost_full;

  // A full FIFO still takes a push when a pop frees the slot in the same cycle;
  // an empty FIFO never bypasses push data to the read side.
  assign wr_ok = push && (!flg.full || pop);
  assign rd_ok = pop && !flg.empty;
  assign ovf   = push && flg.full && !pop;
  assign udf   = pop && flg.empty;

  always_comb begin
    err_nxt = error;
`ifdef FIFO_UMBRAL_ERR_CLR_EN
    if (err_clr) err_nxt = 1'b0;
`endif
    if (ovf || udf) err_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      error     <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      error     <= err_nxt;
      valid_out <= rd_ok;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed scoreboard bench for fifo_umbral; exercises err_clr when
// FIFO_UMBRAL_ERR_CLR_EN is defined.
module tb_fifo_umbral;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0, pop = 1'b0;
  logic [5:0] data_in = '0;
  logic [4:0] umbral_low = 5'd2, umbral_high = 5'd6;
  logic [5:0] data_out;
  logic       valid_out, empty, full, almost_empty, almost_full, error;
  logic [3:0] count;
  bit         clr_req = 1'b0;
`ifdef FIFO_UMBRAL_ERR_CLR_EN
  logic       err_clr;
  assign err_clr = clr_req;
`endif

  int checks = 0;
  int errors = 0;

  logic [5:0] model_q[$];
  logic [5:0] sb[$];
  bit         m_err = 1'b0;
  bit         exp_valid = 1'b0;
  logic [5:0] last_data = '0;

  always #5 clk = ~clk;

  fifo_umbral dut (
    .clk          (clk),
    .reset        (reset),
`ifdef FIFO_UMBRAL_ERR_CLR_EN
    .err_clr      (err_clr),
`endif
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .umbral_low   (umbral_low),
    .umbral_high  (umbral_high),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .error        (error),
    .count        (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed state is {count, empty, full, almost_empty, almost_full, error}.
  task automatic check_state(input string tag);
    int n;
    logic [8:0] exp_s, obs_s;
    logic [5:0] e;
    n     = model_q.size();
    exp_s = {4'(n), n == 0, n == 8, 5'(n) <= umbral_low, 5'(n) >= umbral_high, m_err};
    obs_s = {count, empty, full, almost_empty, almost_full, error};
    chk({tag, "/state"}, 32'(obs_s), 32'(exp_s));
    chk({tag, "/valid"}, 32'(valid_out), 32'(exp_valid));
    if (valid_out === 1'b1 && sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "/data"}, 32'(data_out), 32'(e));
    end else if (valid_out === 1'b1) begin
      chk({tag, "/sb_underrun"}, 32'(sb.size()), 32'd1);
    end else begin
      chk({tag, "/hold"}, 32'(data_out), 32'(last_data));
    end
  endtask

  task automatic step(input bit p, input logic [5:0] d, input bit q, input string tag);
    int n;
    bit wr, rd, ovf, udf;
    logic [5:0] e;
    n   = model_q.size();
    wr  = p && (n < 8 || q);
    rd  = q && n > 0;
    ovf = p && n == 8 && !q;
    udf = q && n == 0;
    push = p; data_in = d; pop = q;
    if (clr_req && !(ovf || udf)) m_err = 1'b0;
    if (ovf || udf) m_err = 1'b1;
    exp_valid = rd;
    if (rd) begin
      e = model_q.pop_front();
      sb.push_back(e);
      last_data = e;
    end
    if (wr) model_q.push_back(d);
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    check_state(tag);
  endtask

  task automatic rst();
    reset = 1'b1; push = 1'b0; pop = 1'b0;
    model_q.delete(); sb.delete();
    m_err = 1'b0; exp_valid = 1'b0; last_data = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_state("reset");
  endtask

  task automatic fill8();
    for (int i = 1; i <= 8; i++) step(1'b1, 6'(i), 1'b0, "fill");
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 6'h00, 1'b1, "drain");
  endtask

  initial begin
    rst();
    step(1'b0, 6'h00, 1'b0, "idle");

    // Watermark walk up and ordered drain.
    fill8();
    drain(8);

    // Overflow drops 0x3F; error stays sticky through the drain and idle.
    fill8();
    step(1'b1, 6'h3F, 1'b0, "overflow");
    drain(8);
    step(1'b0, 6'h00, 1'b0, "err_sticky");

    // Full push+pop: 0x15 becomes the 8th read.
    rst();
    fill8();
    step(1'b1, 6'h15, 1'b1, "full_pushpop");
    drain(8);

    // Empty push+pop: underflow, no bypass.
    step(1'b1, 6'h2A, 1'b1, "empty_pushpop");
    step(1'b0, 6'h00, 1'b1, "pop_2a");

    // Alternating traffic wraps both pointers twice.
    rst();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 6'(8'h20 + i), 1'b0, "alt_push");
      step(1'b0, 6'h00, 1'b1, "alt_pop");
    end

    // Reset with three words in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 6'(i + 9), 1'b0, "pre_reset");
    step(1'b0, 6'h00, 1'b1, "underflow_free_pop");
    step(1'b1, 6'h0C, 1'b0, "pre_reset2");
    rst();

    // Out-of-range thresholds: almost_full never, almost_empty always.
    umbral_high = 5'd9; umbral_low = 5'd8;
    fill8();
    drain(8);
    umbral_high = 5'd16; umbral_low = 5'd31;
    step(1'b0, 6'h00, 1'b0, "thr_far");

    // Zero thresholds: almost_full from reset, almost_empty only at zero.
    umbral_high = 5'd0; umbral_low = 5'd0;
    rst();
    step(1'b1, 6'h11, 1'b0, "thr_zero_push");
    step(1'b0, 6'h00, 1'b1, "thr_zero_pop");
    umbral_high = 5'd6; umbral_low = 5'd2;

`ifdef FIFO_UMBRAL_ERR_CLR_EN
    fill8();
    step(1'b1, 6'h3F, 1'b0, "clr_ovf");
    clr_req = 1'b1;
    step(1'b0, 6'h00, 1'b0, "err_clr");
    clr_req = 1'b0;
    drain(8);
    clr_req = 1'b1;
    step(1'b0, 6'h00, 1'b1, "clr_vs_udf");
    clr_req = 1'b0;
    step(1'b0, 6'h00, 1'b0, "after_clr_vs_udf");
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
